sdram_arbiter: RTL and testbench

Sequences and shares the SDRAM command engine between the display read path, the capture write path and periodic refresh. The arbiter takes burst requests with linear {bank,row,col} addresses and tracks refresh debt. It chooses one operation at a time and hands it to the engine over a valid/ready/done handshake. The engine owns all SDRAM timing; the arbiter owns ordering and fairness.

---
 rtl/sdram_pkg.sv | 27 ++
 rtl/sdram_refresh_timer.sv | 63 ++++++
 rtl/sdram_arbiter.sv | 139 +++++++++++++
 tb/tb_sdram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter: operation codes, address packing,
// arbiter state encoding and refresh debt type.
package sdram_pkg;

  localparam int unsigned BANK_W = 2;
  localparam int unsigned ROW_W  = 13;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_REFRESH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } arb_state_e;

  typedef logic [1:0] debt_t;

  localparam debt_t DEBT_MAX = 2'd3;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer with saturating refresh debt and a sticky overflow
// flag raised when a tick arrives while the debt is already at its maximum.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 3600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       refresh_accept,
  output logic [1:0] debt,
  output logic       refresh_overflow
);

  localparam int unsigned TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] LAST = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0] timer_q, timer_d;
  debt_t         debt_q, debt_d;
  logic          ovf_q, ovf_d;
  logic          tick;

  // Next-state for timer, debt and overflow; the timer restarts from zero
  // whenever it is disabled so each enable period begins a full interval.
  always_comb begin
    tick    = enable && (timer_q == LAST);
    timer_d = timer_q;
    debt_d  = debt_q;
    ovf_d   = ovf_q;
    if (!enable || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    if (tick && !refresh_accept) begin
      if (debt_q == DEBT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        debt_d = debt_q + 2'd1;
      end
    end else if (!tick && refresh_accept && (debt_q != '0)) begin
      debt_d = debt_q - 2'd1;
    end
  end

  // Register timer state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      debt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      debt_q  <= debt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign debt             = debt_q;
  assign refresh_overflow = ovf_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM command engine between display reads, capture writes
// and refresh; one operation at a time over a valid/ready/done handshake.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 3600,
  parameter int unsigned LOW_WM           = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_level,
  output logic              rd_gnt,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  input  logic              cmd_done,
  output logic              busy,
  output logic              refresh_overflow
);

  localparam logic [7:0] LOW_WM_L = 8'(LOW_WM);

  arb_state_e        state_q;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              busy_q;
  logic              last_rd_q;

  op_e               sel_op_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic              accept;
  logic              refresh_accept;
  logic [1:0]        debt;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk              (clk),
    .rst              (rst),
    .enable           (init_done),
    .refresh_accept   (refresh_accept),
    .debt             (debt),
    .refresh_overflow (refresh_overflow)
  );

  assign accept         = valid_q && cmd_ready;
  assign rd_gnt         = accept && (op_q == OP_READ);
  assign wr_gnt         = accept && (op_q == OP_WRITE);
  assign refresh_accept = accept && (op_q == OP_REFRESH);

  // Priority select: heavy refresh debt, urgent read, pending refresh,
  // alternating tie-break, then whichever single request is present.
  always_comb begin
    sel_op_d   = OP_NONE;
    sel_addr_d = '0;
    if (debt >= 2'd2) begin
      sel_op_d = OP_REFRESH;
    end else if (rd_req && (rd_level < LOW_WM_L)) begin
      sel_op_d   = OP_READ;
      sel_addr_d = rd_addr;
    end else if (debt == 2'd1) begin
      sel_op_d = OP_REFRESH;
    end else if (rd_req && wr_req) begin
      if (last_rd_q) begin
        sel_op_d   = OP_WRITE;
        sel_addr_d = wr_addr;
      end else begin
        sel_op_d   = OP_READ;
        sel_addr_d = rd_addr;
      end
    end else if (rd_req) begin
      sel_op_d   = OP_READ;
      sel_addr_d = rd_addr;
    end else if (wr_req) begin
      sel_op_d   = OP_WRITE;
      sel_addr_d = wr_addr;
    end
  end

  // Arbiter FSM with registered command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      last_rd_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init_done && (sel_op_d != OP_NONE)) begin
            op_q    <= sel_op_d;
            addr_q  <= sel_addr_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            valid_q <= 1'b0;
            state_q <= ST_WAIT;
            if (op_q == OP_READ) begin
              last_rd_q <= 1'b1;
            end else if (op_q == OP_WRITE) begin
              last_rd_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (cmd_done) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_op    = op_q;
  assign cmd_addr  = addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a scoreboard of expected commands
// for the data paths plus cycle-exact refresh checks on a short-interval copy.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam logic [24:0] RD_BASE = 25'h0012345;
  localparam logic [24:0] WR_BASE = 25'h1A00040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: long refresh interval so data tests are undisturbed.
  logic        rst = 1'b1, init_done = 1'b0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [24:0] rd_addr = '0, wr_addr = '0;
  logic [7:0]  rd_level = 8'd200;
  logic        cmd_ready = 1'b0, cmd_done = 1'b0;
  logic        rd_gnt, wr_gnt, cmd_valid, busy, refresh_overflow;
  logic [1:0]  cmd_op;
  logic [24:0] cmd_addr;

  // Refresh instance: interval 16, no data requests.
  logic        r_rst = 1'b1, r_init_done = 1'b0, r_cmd_ready = 1'b0, r_cmd_done = 1'b0;
  logic        z_req = 1'b0;
  logic [24:0] z_addr = '0;
  logic [7:0]  z_level = 8'd200;
  logic        r_rd_gnt, r_wr_gnt, r_cmd_valid, r_busy, r_ovf;
  logic [1:0]  r_cmd_op;
  logic [24:0] r_cmd_addr;

  sdram_arbiter #(.REFRESH_INTERVAL(5000), .LOW_WM(64)) u_dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_level(rd_level), .rd_gnt(rd_gnt),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .busy(busy), .refresh_overflow(refresh_overflow)
  );

  sdram_arbiter #(.REFRESH_INTERVAL(16), .LOW_WM(64)) u_ref (
    .clk(clk), .rst(r_rst), .init_done(r_init_done),
    .rd_req(z_req), .rd_addr(z_addr), .rd_level(z_level), .rd_gnt(r_rd_gnt),
    .wr_req(z_req), .wr_addr(z_addr), .wr_gnt(r_wr_gnt),
    .cmd_valid(r_cmd_valid), .cmd_op(r_cmd_op), .cmd_addr(r_cmd_addr),
    .cmd_ready(r_cmd_ready), .cmd_done(r_cmd_done),
    .busy(r_busy), .refresh_overflow(r_ovf)
  );

  typedef struct {
    logic [1:0]  op;
    logic [24:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_dly = 4, done_cnt = 0, accepted = 0, stop_after = 0;
  int   rd_cnt = 0, wr_cnt = 0, lvl_switch = -1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [24:0] rd_a(input int n);
    return RD_BASE + 25'(n << 10);
  endfunction

  function automatic logic [24:0] wr_a(input int n);
    return WR_BASE + 25'(n << 10);
  endfunction

  task automatic push(input op_e op, input logic [24:0] addr);
    exp_t e;
    e.op   = op;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  // One cycle: sample at negedge, model the engine and requesters of u_dut.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cmd_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) cmd_done = 1'b1;
    end
    if (cmd_valid && cmd_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_cmd", {30'd0, cmd_op}, {30'd0, OP_NONE});
      end else begin
        e = exp_q.pop_front();
        check_eq("cmd_op", {30'd0, cmd_op}, {30'd0, e.op});
        check_eq("cmd_addr", {7'd0, cmd_addr}, {7'd0, e.addr});
        check_eq("rd_gnt", {31'd0, rd_gnt}, {31'd0, (e.op == OP_READ)});
        check_eq("wr_gnt", {31'd0, wr_gnt}, {31'd0, (e.op == OP_WRITE)});
      end
      accepted++;
      if (done_dly > 0) done_cnt = done_dly;
      if (rd_gnt) begin
        rd_cnt++;
        rd_addr = rd_a(rd_cnt);
        if (rd_cnt == lvl_switch) rd_level = 8'd200;
      end
      if (wr_gnt) begin
        wr_cnt++;
        wr_addr = wr_a(wr_cnt);
      end
      if (accepted == stop_after) begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
    end else if (rd_gnt || wr_gnt) begin
      check_eq("spurious_gnt", {30'd0, rd_gnt, wr_gnt}, 32'd0);
    end
  endtask

  task automatic reset_main();
    rst = 1'b1; init_done = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    step();
    rst = 1'b0;
    done_cnt = 0; accepted = 0; stop_after = 0;
    rd_cnt = 0; wr_cnt = 0; lvl_switch = -1;
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_cnt != 0) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_pending", exp_q.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    int k;

    // Single read with reset-state and timing checks.
    reset_main();
    check_eq("rst_valid", {31'd0, cmd_valid}, 0);
    check_eq("rst_op", {30'd0, cmd_op}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_ovf", {31'd0, refresh_overflow}, 0);
    init_done = 1'b1; rd_level = 8'd200; cmd_ready = 1'b1; done_dly = 4; stop_after = 1;
    rd_addr = RD_BASE;
    push(OP_READ, RD_BASE);
    rd_req = 1'b1;
    step();
    check_eq("t1_valid_n1", {31'd0, cmd_valid}, 1);
    check_eq("t1_busy_n1", {31'd0, busy}, 1);
    step();
    check_eq("t1_gnt_pulse_end", {31'd0, rd_gnt}, 0);
    check_eq("t1_valid_dropped", {31'd0, cmd_valid}, 0);
    repeat (3) step();
    check_eq("t1_busy_at_done", {31'd0, busy}, 1);
    step();
    check_eq("t1_idle_after_done", {31'd0, busy}, 0);
    drain(50);

    // Both requests held, level high: strict alternation R,W,R,W...
    reset_main();
    init_done = 1'b1; rd_level = 8'd200; done_dly = 4; stop_after = 8;
    rd_addr = rd_a(0); wr_addr = wr_a(0);
    for (int i = 0; i < 4; i++) begin
      push(OP_READ, rd_a(i));
      push(OP_WRITE, wr_a(i));
    end
    rd_req = 1'b1; wr_req = 1'b1;
    drain(200);

    // Urgent reads starve writes until the level recovers after 4 reads.
    reset_main();
    init_done = 1'b1; rd_level = 8'd10; done_dly = 4; stop_after = 6; lvl_switch = 4;
    rd_addr = rd_a(0); wr_addr = wr_a(0);
    for (int i = 0; i < 4; i++) push(OP_READ, rd_a(i));
    push(OP_WRITE, wr_a(0));
    push(OP_READ, rd_a(4));
    rd_req = 1'b1; wr_req = 1'b1;
    drain(200);

    // Reset while waiting on the engine.
    reset_main();
    init_done = 1'b1; done_dly = 0; stop_after = 1;
    wr_addr = wr_a(7);
    push(OP_WRITE, wr_a(7));
    wr_req = 1'b1;
    repeat (4) step();
    check_eq("t6_busy_wait", {31'd0, busy}, 1);
    rst = 1'b1; init_done = 1'b0;
    step();
    check_eq("t6_valid", {31'd0, cmd_valid}, 0);
    check_eq("t6_op", {30'd0, cmd_op}, 0);
    check_eq("t6_addr", {7'd0, cmd_addr}, 0);
    check_eq("t6_gnts", {30'd0, rd_gnt, wr_gnt}, 0);
    check_eq("t6_busy", {31'd0, busy}, 0);
    check_eq("t6_ovf", {31'd0, refresh_overflow}, 0);
    rst = 1'b0;
    repeat (8) step();
    init_done = 1'b1;
    repeat (5) step();
    check_eq("t6_no_cmd", {31'd0, cmd_valid}, 0);
    done_dly = 3; stop_after = 2;
    wr_addr = wr_a(9);
    push(OP_WRITE, wr_a(9));
    wr_req = 1'b1;
    drain(50);

    // Refresh: first command after init_done, then debt back to zero.
    r_rst = 1'b1;
    step();
    r_rst = 1'b0;
    step();
    check_eq("r_rst_valid", {31'd0, r_cmd_valid}, 0);
    check_eq("r_rst_ovf", {31'd0, r_ovf}, 0);
    r_init_done = 1'b1; r_cmd_ready = 1'b1;
    k = 0;
    while (!r_cmd_valid && k < 40) begin step(); k++; end
    check_eq("ref_first_cycle", k, 17);
    check_eq("ref_op", {30'd0, r_cmd_op}, {30'd0, OP_REFRESH});
    check_eq("ref_addr", {7'd0, r_cmd_addr}, 0);
    check_eq("ref_no_data_gnt", {30'd0, r_rd_gnt, r_wr_gnt}, 0);
    step();
    check_eq("ref_valid_dropped", {31'd0, r_cmd_valid}, 0);
    step(); r_cmd_done = 1'b1; k += 2;
    step(); r_cmd_done = 1'b0; k++;
    while (!r_cmd_valid && k < 60) begin step(); k++; end
    check_eq("ref_second_cycle", k, 33);
    step(); step(); r_cmd_done = 1'b1;
    step(); r_cmd_done = 1'b0;

    // Refresh never accepted: debt saturates, fourth tick overflows.
    r_rst = 1'b1; r_init_done = 1'b0; r_cmd_ready = 1'b0;
    step();
    r_rst = 1'b0; r_init_done = 1'b1;
    repeat (63) step();
    check_eq("ovf_before_4th", {31'd0, r_ovf}, 0);
    step();
    check_eq("ovf_at_4th", {31'd0, r_ovf}, 1);
    check_eq("ovf_held_valid", {31'd0, r_cmd_valid}, 1);
    r_cmd_ready = 1'b1;
    repeat (40) step();
    check_eq("ovf_sticky", {31'd0, r_ovf}, 1);
    r_rst = 1'b1;
    step();
    check_eq("ovf_cleared", {31'd0, r_ovf}, 0);
    check_eq("ovf_rst_busy", {31'd0, r_busy}, 0);
    r_rst = 1'b0; r_init_done = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
